// File: rtl/ahb_mult_engine.sv
// rtl/ahb_mult_engine.sv - AHB-Lite slave wrapping an iterative shift-add multiplier
// Signed/unsigned operands are snapshotted at start; status, W1C done/overrun and a level irq.
module ahb_mult_engine #(
  parameter int DATA_W  = 16,
  parameter bit IRQ_RST = 1'b0
) (
  input  logic        AHB_HCLK,
  input  logic        AHB_HRESET,
  input  logic        AHB_HSEL,
  input  logic [31:0] AHB_HADDR,
  input  logic [1:0]  AHB_HTRANS,
  input  logic        AHB_HWRITE,
  input  logic [2:0]  AHB_HSIZE,
  input  logic [31:0] AHB_HWDATA,
  output logic [31:0] AHB_HRDATA,
  output logic        AHB_HREADY,
  output logic [1:0]  AHB_HRESP,
  output logic        irq
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [7:0]        addr_q;
  logic              sel_q, trans_q, write_q;
  logic [DATA_W-1:0] op_a, op_b, mer;
  logic [PW-1:0]     acc, mcand;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, sgn_q, sgn_mode, irq_en, done, busy, overrun;
  logic [63:0]       res;

  logic              wr_en, rd_en, ctrl_wr, start_req, start_sgn;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [PW-1:0]     acc_next, prod;
  logic [63:0]       res_ext;
  logic              unused;

  assign wr_en     = sel_q & trans_q & write_q;
  assign rd_en     = sel_q & trans_q & ~write_q;
  assign ctrl_wr   = wr_en && (addr_q == 8'h08);
  assign start_req = ctrl_wr & AHB_HWDATA[0];
  // The signed bit written together with start governs this operation.
  assign start_sgn = AHB_HWDATA[3];
  assign mag_a     = (start_sgn & op_a[DATA_W-1]) ? -op_a : op_a;
  assign mag_b     = (start_sgn & op_b[DATA_W-1]) ? -op_b : op_b;
  assign acc_next  = mer[0] ? acc + mcand : acc;
  assign prod      = neg_q ? -acc : acc;

  // Upper result bits carry the sign in signed mode, zeros otherwise.
  always_comb begin
    res_ext = {64{sgn_q & prod[PW-1]}};
    res_ext[PW-1:0] = prod;
  end

  always_ff @(posedge AHB_HCLK) begin
    if (AHB_HRESET) begin
      state    <= IDLE;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      trans_q  <= 1'b0;
      write_q  <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      mer      <= '0;
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      sgn_mode <= 1'b0;
      irq_en   <= IRQ_RST;
      done     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      res      <= '0;
    end else begin
      addr_q  <= AHB_HADDR[7:0];
      sel_q   <= AHB_HSEL;
      trans_q <= AHB_HTRANS[1];
      write_q <= AHB_HWRITE;

      if (wr_en && addr_q == 8'h00) op_a <= AHB_HWDATA[DATA_W-1:0];
      if (wr_en && addr_q == 8'h04) op_b <= AHB_HWDATA[DATA_W-1:0];

      // W1C first so that a same-edge set below takes priority.
      if (ctrl_wr) begin
        sgn_mode <= AHB_HWDATA[3];
        irq_en   <= AHB_HWDATA[4];
        if (AHB_HWDATA[1]) done    <= 1'b0;
        if (AHB_HWDATA[5]) overrun <= 1'b0;
      end
      if (start_req && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start_req) begin
            mcand <= PW'(mag_a);
            mer   <= mag_b;
            neg_q <= start_sgn & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            sgn_q <= start_sgn;
            acc   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mer   <= mer >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FINISH;
        end
        FINISH: begin
          res   <= res_ext;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    AHB_HRDATA = 32'hFFFF_FFFF;
    if (rd_en) begin
      case (addr_q)
        8'h00: begin
          AHB_HRDATA = '0;
          AHB_HRDATA[DATA_W-1:0] = op_a;
        end
        8'h04: begin
          AHB_HRDATA = '0;
          AHB_HRDATA[DATA_W-1:0] = op_b;
        end
        8'h08:   AHB_HRDATA = {26'd0, overrun, irq_en, sgn_mode, busy, done, 1'b0};
        8'h0C:   AHB_HRDATA = res[31:0];
        8'h10:   AHB_HRDATA = res[63:32];
        default: AHB_HRDATA = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign AHB_HREADY = 1'b1;
  assign AHB_HRESP  = 2'b00;
  assign irq        = done & irq_en;
  assign unused     = ^{AHB_HSIZE, AHB_HADDR[31:8], AHB_HWDATA, AHB_HTRANS[0]};

endmodule
